// File: rtl/alu_issue_arbiter.sv
// Shares one combinational RV32I ALU among N_REQ requesters with a one-entry result register.
// Define ALU_ARB_RR_EN for round-robin grant; otherwise fixed priority (lowest index wins).

module alu_issue_alu #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      funct3,
    input  logic            sign,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] shamt;
    assign shamt = b[SH_W-1:0];

    always_comb begin
        result = '0;
        case (funct3)
            3'b000: result = sign ? (a - b) : (a + b);
            3'b001: result = a << shamt;
            3'b010: result = XLEN'($signed(a) < $signed(b));
            3'b011: result = XLEN'(a < b);
            3'b100: result = a ^ b;
            3'b101: begin
                // Kept out of a ternary: mixing with the unsigned branch would make >>> logical.
                if (sign) result = $signed(a) >>> shamt;
                else      result = a >> shamt;
            end
            3'b110: result = a | b;
            3'b111: result = a & b;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);
endmodule

module alu_issue_arbiter #(
    parameter int XLEN  = 32,
    parameter int N_REQ = 4,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*XLEN-1:0]  req_a,
    input  logic [N_REQ*XLEN-1:0]  req_b,
    input  logic [N_REQ*3-1:0]     req_funct3,
    input  logic [N_REQ-1:0]       req_sign,
    input  logic [N_REQ*TAG_W-1:0] req_tag,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [XLEN-1:0]        res_value,
    output logic                   res_zero,
    output logic [TAG_W-1:0]       res_tag
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam logic [PTR_W:0]   LAST_W = (PTR_W+1)'(N_REQ - 1);
    localparam logic [PTR_W:0]   NREQ_W = (PTR_W+1)'(N_REQ);
    localparam logic [PTR_W-1:0] LAST   = PTR_W'(N_REQ - 1);

    logic             res_valid_q, res_valid_d;
    logic [XLEN-1:0]  res_value_q, res_value_d;
    logic             res_zero_q,  res_zero_d;
    logic [TAG_W-1:0] res_tag_q,   res_tag_d;
`ifdef ALU_ARB_RR_EN
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
`endif

    logic             can_load;
    logic             grant_found;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W:0]   cand;
    logic             issue;
    logic [XLEN-1:0]  alu_result;
    logic             alu_zero;

    // No handshake is offered while reset is held.
    assign can_load = rst_n & ~flush & (~res_valid_q | res_ready);

    // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef ALU_ARB_RR_EN
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (cand > LAST_W) cand = cand - NREQ_W;
`else
            cand = (PTR_W+1)'(k);
`endif
            if (!grant_found && req_valid[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    assign issue = can_load & grant_found;

    always_comb begin
        req_ready = '0;
        if (issue) req_ready[grant_idx] = 1'b1;
    end

    alu_issue_alu #(.XLEN(XLEN)) u_alu (
        .a      (req_a[grant_idx*XLEN +: XLEN]),
        .b      (req_b[grant_idx*XLEN +: XLEN]),
        .funct3 (req_funct3[grant_idx*3 +: 3]),
        .sign   (req_sign[grant_idx]),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Flush beats both a pending issue and the result-bus accept.
    always_comb begin
        res_valid_d = res_valid_q;
        res_value_d = res_value_q;
        res_zero_d  = res_zero_q;
        res_tag_d   = res_tag_q;
        if (flush) begin
            res_valid_d = 1'b0;
        end else if (issue) begin
            res_valid_d = 1'b1;
            res_value_d = alu_result;
            res_zero_d  = alu_zero;
            res_tag_d   = req_tag[grant_idx*TAG_W +: TAG_W];
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

`ifdef ALU_ARB_RR_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (issue) rr_ptr_d = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_value_q <= '0;
            res_zero_q  <= 1'b0;
            res_tag_q   <= '0;
`ifdef ALU_ARB_RR_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            res_valid_q <= res_valid_d;
            res_value_q <= res_value_d;
            res_zero_q  <= res_zero_d;
            res_tag_q   <= res_tag_d;
`ifdef ALU_ARB_RR_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign res_valid = res_valid_q;
    assign res_value = res_value_q;
    assign res_zero  = res_zero_q;
    assign res_tag   = res_tag_q;
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Scoreboard bench for alu_issue_arbiter: expected results are queued at issue and compared on drain.
// Grant expectations follow ALU_ARB_RR_EN the same way the design does.

module tb_alu_issue_arbiter;
    localparam int XLEN  = 32;
    localparam int N_REQ = 4;
    localparam int TAG_W = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   flush;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*XLEN-1:0]  req_a;
    logic [N_REQ*XLEN-1:0]  req_b;
    logic [N_REQ*3-1:0]     req_funct3;
    logic [N_REQ-1:0]       req_sign;
    logic [N_REQ*TAG_W-1:0] req_tag;
    logic                   res_valid;
    logic                   res_ready;
    logic [XLEN-1:0]        res_value;
    logic                   res_zero;
    logic [TAG_W-1:0]       res_tag;

    alu_issue_arbiter #(.XLEN(XLEN), .N_REQ(N_REQ), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_funct3 (req_funct3),
        .req_sign   (req_sign),
        .req_tag    (req_tag),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_value  (res_value),
        .res_zero   (res_zero),
        .res_tag    (res_tag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [XLEN-1:0]  value;
        logic             zero;
        logic [TAG_W-1:0] tag;
    } res_t;

    res_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic exp_valid = 1'b0;
    int   exp_ptr = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] alu_ref(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                                input logic [2:0] f3, input logic sign);
        logic [XLEN-1:0] r;
        int sh;
        sh = int'(b[4:0]);
        r = '0;
        case (f3)
            3'b000: r = sign ? a - b : a + b;
            3'b001: r = a << sh;
            3'b010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b011: r = (a < b) ? 32'd1 : 32'd0;
            3'b100: r = a ^ b;
            3'b101: begin
                if (sign) r = $signed(a) >>> sh;
                else      r = a >> sh;
            end
            3'b110: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic logic [N_REQ-1:0] exp_grant(input logic [N_REQ-1:0] v, input int ptr);
        logic [N_REQ-1:0] g;
        g = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (v[(ptr + k) % N_REQ]) begin
                g = '0;
                g[(ptr + k) % N_REQ] = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic set_req(input int i, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [2:0] f3, input logic sign, input logic [TAG_W-1:0] tag);
        req_a[i*XLEN +: XLEN]       = a;
        req_b[i*XLEN +: XLEN]       = b;
        req_funct3[i*3 +: 3]        = f3;
        req_sign[i]                 = sign;
        req_tag[i*TAG_W +: TAG_W]   = tag;
    endtask

    // One clock: check grant and result at the falling edge, advance the model, return after the rising edge.
    task automatic step(input string tag);
        logic             can;
        logic [N_REQ-1:0] g_exp;
        res_t             e;
        int               idx;
        @(negedge clk);
        can = !flush && (!exp_valid || res_ready);
`ifdef ALU_ARB_RR_EN
        g_exp = can ? exp_grant(req_valid, exp_ptr) : '0;
`else
        g_exp = can ? exp_grant(req_valid, 0) : '0;
`endif
        check({tag, "_ready"}, 64'(req_ready), 64'(g_exp));
        check({tag, "_valid"}, 64'(res_valid), 64'(exp_valid));
        if (exp_valid && (res_ready || flush)) begin
            check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'(1));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({tag, "_value"}, 64'(res_value), 64'(e.value));
                check({tag, "_zero"},  64'(res_zero),  64'(e.zero));
                check({tag, "_tag"},   64'(res_tag),   64'(e.tag));
            end
        end
        if (flush) begin
            exp_valid = 1'b0;
        end else if (g_exp != '0) begin
            idx = 0;
            for (int i = 0; i < N_REQ; i++) if (g_exp[i]) idx = i;
            e.value = alu_ref(req_a[idx*XLEN +: XLEN], req_b[idx*XLEN +: XLEN],
                              req_funct3[idx*3 +: 3], req_sign[idx]);
            e.zero  = (e.value == '0);
            e.tag   = req_tag[idx*TAG_W +: TAG_W];
            sb.push_back(e);
            exp_valid = 1'b1;
            exp_ptr   = (idx + 1) % N_REQ;
        end else if (res_ready) begin
            exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        res_ready  = 1'b1;
        req_valid  = 4'b1111;
        for (int i = 0; i < N_REQ; i++)
            set_req(i, $urandom, $urandom, 3'($urandom), 1'($urandom), 4'($urandom));

        // Reset held with every requester asking.
        repeat (2) @(posedge clk);
        #1;
        check("t1_ready_rst", 64'(req_ready), 64'(0));
        check("t1_valid_rst", 64'(res_valid), 64'(0));
        check("t1_value_rst", 64'(res_value), 64'(0));
        check("t1_zero_rst",  64'(res_zero),  64'(0));
        check("t1_tag_rst",   64'(res_tag),   64'(0));
        rst_n = 1'b1;
        #1;
        check("t1_ready_rel", 64'(req_ready), 64'(4'b0001));

        // Single op: 5 - 3.
        set_req(0, 32'd5, 32'd3, 3'b000, 1'b1, 4'd7);
        req_valid = 4'b0001;
        step("t2_issue");
        check("t2_res_valid", 64'(res_valid), 64'(1));
        check("t2_res_value", 64'(res_value), 64'(2));
        check("t2_res_zero",  64'(res_zero),  64'(0));
        check("t2_res_tag",   64'(res_tag),   64'(7));

        // All requesting, bus always accepting.
        for (int i = 0; i < N_REQ; i++)
            set_req(i, $urandom, $urandom, 3'(i), 1'(i), 4'(i + 8));
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) step("t3_rr");

        // Stall: result held, no grant, value stable.
        res_ready = 1'b0;
        req_valid = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            step("t4_stall");
            check("t4_hold", 64'(res_value), 64'(sb[0].value));
        end
        res_ready = 1'b1;
        step("t4_go");
        req_valid = 4'b0000;

        // Arithmetic shift right and a zero result.
        set_req(2, 32'h8000_0000, 32'd4, 3'b101, 1'b1, 4'd3);
        req_valid = 4'b0100;
        step("t5_sra");
        check("t5_sra_value", 64'(res_value), 64'(32'hF800_0000));
        check("t5_sra_zero",  64'(res_zero),  64'(0));
        set_req(2, 32'd9, 32'd9, 3'b100, 1'b1, 4'd4);
        step("t5_xor");
        check("t5_xor_value", 64'(res_value), 64'(0));
        check("t5_xor_zero",  64'(res_zero),  64'(1));

        // Flush with a held result and a pending request.
        res_ready = 1'b0;
        flush     = 1'b1;
        step("t6_flush");
        flush = 1'b0;
        check("t6_valid_after", 64'(res_valid), 64'(0));
        res_ready = 1'b1;
        req_valid = 4'b1111;
        for (int c = 0; c < 4; c++) step("t6_resume");

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < N_REQ; i++)
                set_req(i, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                        3'($urandom), 1'($urandom), 4'($urandom));
            step("rnd");
        end
        flush = 1'b0;

        // Reset during a stall discards the held result.
        req_valid = 4'b0001;
        res_ready = 1'b1;
        step("t8_load");
        res_ready = 1'b0;
        step("t8_stall");
        check("t8_valid_pre", 64'(res_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        check("t8_valid_rst", 64'(res_valid), 64'(0));
        check("t8_value_rst", 64'(res_value), 64'(0));
        check("t8_tag_rst",   64'(res_tag),   64'(0));
        check("t8_ready_rst", 64'(req_ready), 64'(0));
        sb.delete();
        exp_valid = 1'b0;
        exp_ptr   = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = 4'b1010;
        res_ready = 1'b1;
        for (int c = 0; c < 3; c++) step("t8_post");

        // Drain.
        req_valid = 4'b0000;
        for (int c = 0; c < 4 && exp_valid; c++) step("drain");
        check("sb_drained", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
